// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier issue/collect controller.
//   mic_state_t : controller state encoding (IDLE, RUN, DONE)
//   OP_W        : operand width of the shift-add multiplier
//   PROD_W      : product width of the shift-add multiplier
//   MIC_TIMEOUT : default number of RUN cycles allowed before a run is aborted
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mic_state_t;

    localparam int OP_W        = 32;
    localparam int PROD_W      = 64;
    localparam int MIC_TIMEOUT = 40;

endpackage

// File: rtl/mult_issue_ctrl.sv
// Issue/collect controller in front of the 32x32 iterative shift-add multiplier.
// Accepts one operand pair, holds it on the multiplier inputs for the whole run,
// captures the product on the first cycle fin is seen, then offers the result
// downstream. A run that never sees fin is aborted after TIMEOUT cycles.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake (in_ready only in IDLE)
//   in_a, in_b           : multiplicand / multiplier operand
//   m_reset              : multiplier reset (low only while running)
//   m_mcand, m_mplier    : registered operands driven to the multiplier
//   m_prod, m_fin        : multiplier product and finish flag
//   out_valid/out_ready  : result handshake
//   out_prod, out_err    : captured product, timeout flag (prod is 0 on timeout)
//   busy                 : controller not idle
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | multiplier held in reset, waiting for an operand pair
// RUN   | multiplier running, counting cycles, watching for fin
// DONE  | result (or timeout) presented downstream, multiplier in reset
module mult_issue_ctrl
    import mult_pkg::*;
#(
    parameter int TIMEOUT = MIC_TIMEOUT,
    parameter int CW      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              m_reset,
    output logic [OP_W-1:0]   m_mcand,
    output logic [OP_W-1:0]   m_mplier,
    input  logic [PROD_W-1:0] m_prod,
    input  logic              m_fin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_prod,
    output logic              out_err,
    output logic              busy
);

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    mic_state_t    state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            m_mcand  <= '0;
            m_mplier <= '0;
            out_prod <= '0;
            out_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_mcand  <= in_a;
                        m_mplier <= in_b;
                        cnt      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    // The multiplier keeps shifting prod after fin, so only the
                    // first fin cycle carries the correct product. fin wins over
                    // the timeout when both land on the same cycle.
                    if (m_fin) begin
                        out_prod <= m_prod;
                        out_err  <= 1'b0;
                        state    <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        out_prod <= '0;
                        out_err  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pure decodes of the state register: no path from in_valid/out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    // Multiplier is cleared at the accept edge and frozen again once DONE.
    assign m_reset   = (state != RUN);

endmodule

// File: tb/tb_mult_issue_ctrl.sv
module tb_mult_issue_ctrl;
    import mult_pkg::*;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic        m_reset;
    logic [31:0] m_mcand, m_mplier;
    logic [63:0] m_prod;
    logic        m_fin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_prod;
    logic        out_err;
    logic        busy;

    mult_issue_ctrl #(.TIMEOUT(TMO), .CW(6)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .m_reset(m_reset), .m_mcand(m_mcand), .m_mplier(m_mplier),
        .m_prod(m_prod), .m_fin(m_fin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Multiplier stand-in: counts cycles out of reset; fin rises when the count
    // reaches stub_k, at which point prod holds the payload, and every later
    // cycle shifts it right by one more bit. Real multiplier: stub_k = 33.
    logic        stub_stuck = 1'b0;
    int          stub_k = 33;
    logic        stub_const_en = 1'b0;
    logic [63:0] stub_const = 64'h0;
    int          scnt = 0;
    logic [63:0] payload;

    always @(posedge clk) begin
        if (m_reset) scnt <= 0;
        else if (scnt < 1000) scnt <= scnt + 1;
    end

    always_comb begin
        payload = stub_const_en ? stub_const : (64'(m_mcand) * 64'(m_mplier));
        m_fin   = !stub_stuck && (scnt >= stub_k);
        if (scnt < stub_k) m_prod = 64'(scnt) * 64'h9E37_79B9_7F4A_7C15;
        else               m_prod = payload >> (scnt - stub_k);
    end

    typedef struct {
        logic [63:0] prod;
        logic        err;
        int          lat;
        int          acc;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;
    exp_t q[$];

    // out_ready policy: 0 = tied high, 1 = random, 2 = held low
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor / scoreboard
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [63:0] held_prod;
    logic        held_err;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (out_valid) begin
                check("in_ready_in_done", 64'(in_ready), 64'd0);
                check("m_reset_in_done", 64'(m_reset), 64'd1);
                if (!prev_valid) begin
                    if (q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_out_valid: got out_valid=1, expected 0 (cycle %0d)", cyc);
                    end else begin
                        e = q.pop_front();
                        check("out_prod", out_prod, e.prod);
                        check("out_err", 64'(out_err), 64'(e.err));
                        check("latency", 64'(cyc - e.acc), 64'(e.lat));
                    end
                    held_prod = out_prod;
                    held_err  = out_err;
                end else begin
                    check("out_prod_stable", out_prod, held_prod);
                    check("out_err_stable", 64'(out_err), 64'(held_err));
                end
            end
            if (prev_valid && prev_ready)
                check("consumed_on_ready", 64'(out_valid), 64'd0);
            if (busy && !out_valid && q.size() > 0) begin
                check("m_mcand_held", 64'(m_mcand), 64'(q[0].a));
                check("m_mplier_held", 64'(m_mplier), 64'(q[0].b));
                check("m_reset_in_run", 64'(m_reset), 64'd0);
            end
            if (!busy) check("in_ready_idle", 64'(in_ready), 64'd1);
        end
        prev_valid = out_valid && !reset;
        prev_ready = out_ready;
    end

    int last_acc = 0;

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input int k,
                         input logic stuck, input logic cen, input logic [63:0] cval);
        exp_t e;
        int budget = 0;
        @(negedge clk);
        while (!in_ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_wait: got in_ready=0, expected 1 within 300 cycles");
            return;
        end
        stub_k        = k;
        stub_stuck    = stuck;
        stub_const_en = cen;
        stub_const    = cval;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        e.a   = a;
        e.b   = b;
        e.acc = cyc + 1;
        if (stuck || k >= TMO) begin
            e.err  = 1'b1;
            e.prod = 64'h0;
            e.lat  = TMO;
        end else begin
            e.err  = 1'b0;
            e.prod = cen ? cval : (64'(a) * 64'(b));
            e.lat  = k + 1;
        end
        q.push_back(e);
        last_acc = e.acc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while ((q.size() != 0 || busy) && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        if (q.size() != 0 || busy) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d results pending, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int prev;
        int budget;
        logic [31:0] ra, rb;
        int rk;
        reset = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_m_reset", 64'(m_reset), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_m_mcand", 64'(m_mcand), 64'd0);
        check("rst_out_prod", out_prod, 64'd0);

        // 14 x 13 with downstream stalled for 10 cycles
        rdy_mode = 2;
        issue(32'd14, 32'd13, 33, 1'b0, 1'b0, 64'h0);
        budget = 0;
        while (!out_valid && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("hold_out_valid_seen", 64'(out_valid), 64'd1);
        repeat (10) @(negedge clk);
        check("hold_out_prod", out_prod, 64'd182);
        rdy_mode = 0;
        drain();

        // back-to-back, out_ready tied high
        issue(32'd0, 32'hDEAD, 33, 1'b0, 1'b0, 64'h0);
        prev = last_acc;
        issue(32'hFFFF_FFFF, 32'd1, 33, 1'b0, 1'b0, 64'h0);
        check("issue_interval_1", 64'(last_acc - prev), 64'd36);
        prev = last_acc;
        issue(32'd7, 32'd9, 33, 1'b0, 1'b0, 64'h0);
        check("issue_interval_2", 64'(last_acc - prev), 64'd36);
        drain();

        // reset at cycle 20 of a run, then a clean 14 x 13
        issue(32'd14, 32'd13, 33, 1'b0, 1'b0, 64'h0);
        repeat (19) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        @(negedge clk);
        check("midrun_rst_busy", 64'(busy), 64'd0);
        check("midrun_rst_out_valid", 64'(out_valid), 64'd0);
        check("midrun_rst_m_reset", 64'(m_reset), 64'd1);
        check("midrun_rst_m_mplier", 64'(m_mplier), 64'd0);
        check("midrun_rst_out_err", 64'(out_err), 64'd0);
        repeat (50) @(negedge clk);
        issue(32'd14, 32'd13, 33, 1'b0, 1'b0, 64'h0);
        drain();

        // stuck fin -> timeout; fin exactly at the last allowed cycle and one past
        issue(32'd5, 32'd6, 33, 1'b1, 1'b0, 64'h0);
        issue(32'd3, 32'd11, TMO - 1, 1'b0, 1'b0, 64'h0);
        issue(32'd3, 32'd11, TMO, 1'b0, 1'b0, 64'h0);
        // one-cycle capture window with a known product
        issue(32'd1, 32'd1, 12, 1'b0, 1'b1, 64'h1234);
        issue(32'd1, 32'd1, 1, 1'b0, 1'b1, 64'h1234);
        drain();

        // reset while DONE with out_ready high
        issue(32'd21, 32'd2, 33, 1'b0, 1'b0, 64'h0);
        budget = 0;
        while (!out_valid && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        @(negedge clk);
        check("done_rst_out_valid", 64'(out_valid), 64'd0);
        check("done_rst_out_prod", out_prod, 64'd0);

        // randomized traffic with random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFF;
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            rk = ($urandom_range(0, 9) < 7) ? 33 : int'($urandom_range(1, 45));
            issue(ra, rb, rk, ($urandom_range(0, 15) == 0), 1'b0, 64'h0);
        end
        rdy_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
